// File: rtl/boot_loader.sv
// Streams a length-prefixed, XOR-checksummed program image from a byte link into
// instruction memory, releasing the core from reset only after a verified load.
module boot_loader #(
  parameter int MAX_WORDS = 256,
  parameter int IDX_W     = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  // Byte handshake: a byte moves on a rising edge where in_valid & in_ready.
  // in_ready is registered from the next state, so it never depends on in_valid.

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_RUN, S_ERROR
  } state_t;

  state_t           state, state_nx;
  logic [15:0]      len;
  logic [15:0]      len_in;
  logic [15:0]      idx_inc;
  logic [IDX_W-1:0] idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_word;
  logic [7:0]       csum;
  logic             accept;

  assign accept  = in_valid & in_ready;
  assign len_in  = {len[15:8], in_data};
  assign idx_inc = 16'(idx) + 16'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_IDLE;
      S_LEN_HI: if (accept) state_nx = S_LEN_LO;
      S_LEN_LO: if (accept) begin
        if (len_in > 16'(MAX_WORDS)) state_nx = S_ERROR;
        else if (len_in == 16'd0)    state_nx = S_CHECK;
        else                         state_nx = S_DATA;
      end
      S_DATA:   if (accept && byte_cnt == 2'd3) state_nx = S_WRITE;
      S_WRITE:  state_nx = (idx_inc == len) ? S_CHECK : S_DATA;
      S_CHECK:  if (accept) state_nx = (in_data == csum) ? S_RUN : S_ERROR;
      S_RUN:    state_nx = S_RUN;
      S_ERROR:  state_nx = S_ERROR;
      default:  state_nx = S_IDLE;
    endcase
    // A restart wins over any byte accepted on the same edge.
    if (start) state_nx = S_LEN_HI;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len      <= '0;
      idx      <= '0;
      byte_cnt <= '0;
      asm_word <= '0;
      csum     <= '0;
    end else if (start) begin
      idx      <= '0;
      byte_cnt <= '0;
      csum     <= '0;
    end else begin
      case (state)
        S_LEN_HI: if (accept) begin
          len[15:8] <= in_data;
          csum      <= csum ^ in_data;
        end
        S_LEN_LO: if (accept) begin
          len[7:0] <= in_data;
          csum     <= csum ^ in_data;
          byte_cnt <= '0;
        end
        S_DATA: if (accept) begin
          asm_word <= {asm_word[15:0], in_data};
          csum     <= csum ^ in_data;
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_WRITE: idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      in_ready   <= (state_nx == S_LEN_HI) || (state_nx == S_LEN_LO) ||
                    (state_nx == S_DATA)   || (state_nx == S_CHECK);
      imem_we    <= (state_nx == S_WRITE);
      core_reset <= (state_nx != S_RUN);
      done       <= (state_nx == S_RUN);
      error      <= (state_nx == S_ERROR);
      // Address and data only move on entry to WRITE; imem_we qualifies them.
      if (state_nx == S_WRITE) begin
        imem_addr  <= 32'({idx, 2'b00});
        imem_wdata <= {asm_word, in_data};
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: byte-stream driver, write scoreboard
// keyed on {address, data}, and output checks around each load.
module tb_boot_loader;

  localparam int MAX_WORDS = 256;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words_q[$];

  boot_loader #(.MAX_WORDS(MAX_WORDS), .IDX_W(9)) dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_reset(core_reset),
    .done(done), .error(error)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clock) begin
    if (reset && imem_we) begin
      wr_count++;
      check("we_ready_low", 32'(in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", imem_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e[63:32]);
        check("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        in_valid = 1'b0;
      end
    end
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clock);
  endtask

  task automatic idle_link();
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clock);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Sends words_q as an image; expected writes are queued as bytes are driven.
  task automatic send_image(input bit bad, input bit gaps);
    logic [7:0]  cs;
    logic [15:0] n;
    logic [31:0] w;
    n  = 16'(words_q.size());
    cs = n[15:8] ^ n[7:0];
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    for (int i = 0; i < words_q.size(); i++) begin
      w = words_q[i];
      exp_q.push_back({32'(i * 4), w});
      for (int k = 3; k >= 0; k--) begin
        cs = cs ^ w[k*8 +: 8];
        send_byte(w[k*8 +: 8], gaps);
      end
    end
    send_byte(bad ? (cs ^ 8'h01) : cs, gaps);
  endtask

  task automatic expect_run(input string tag);
    @(negedge clock);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    in_valid = 1'b0;
  endtask

  initial begin
    int wr_before;
    reset    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // reset held with start high
    repeat (3) @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_core_reset", 32'(core_reset), 32'd1);

    // normal two-word load
    words_q = '{32'h2008_0005, 32'h0000_0000};
    wr_before = wr_count;
    do_start();
    check("start_in_ready", 32'(in_ready), 32'd1);
    send_image(1'b0, 1'b0);
    expect_run("normal");
    check("normal_writes", 32'(wr_count - wr_before), 32'd2);

    // bytes in RUN are ignored
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clock);
    in_valid = 1'b0;
    check("run_ignore_done", 32'(done), 32'd1);
    check("run_ignore_ready", 32'(in_ready), 32'd0);

    // bad checksum, then restart and reload
    do_start();
    send_image(1'b1, 1'b0);
    @(negedge clock);
    check("bad_error", 32'(error), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_core_reset", 32'(core_reset), 32'd1);
    in_valid = 1'b0;
    do_start();
    check("restart_error_clear", 32'(error), 32'd0);
    send_image(1'b0, 1'b0);
    expect_run("reload");

    // oversize length rejected straight after LEN_LO
    wr_before = wr_count;
    do_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    check("over_error", 32'(error), 32'd1);
    check("over_in_ready", 32'(in_ready), 32'd0);
    repeat (6) @(negedge clock);
    check("over_writes", 32'(wr_count - wr_before), 32'd0);

    // empty image
    words_q.delete();
    wr_before = wr_count;
    do_start();
    send_image(1'b0, 1'b0);
    expect_run("empty");
    check("empty_writes", 32'(wr_count - wr_before), 32'd0);

    // four words with random gaps
    words_q.delete();
    for (int i = 0; i < 4; i++) words_q.push_back($urandom);
    do_start();
    send_image(1'b0, 1'b1);
    expect_run("gaps");

    // abort during the third data word, then full reload
    do_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({32'(i * 4), words_q[i]});
      for (int k = 3; k >= 0; k--) send_byte(words_q[i][k*8 +: 8], 1'b0);
    end
    send_byte(words_q[2][31:24], 1'b0);
    send_byte(words_q[2][23:16], 1'b0);
    @(negedge clock);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clock);
    start    = 1'b0;
    in_valid = 1'b0;
    check("abort_core_reset", 32'(core_reset), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    send_image(1'b0, 1'b0);
    expect_run("abort_reload");

    // largest legal image, index must not wrap
    words_q.delete();
    for (int i = 0; i < MAX_WORDS; i++) words_q.push_back($urandom);
    wr_before = wr_count;
    do_start();
    send_image(1'b0, 1'b0);
    expect_run("max");
    check("max_writes", 32'(wr_count - wr_before), 32'(MAX_WORDS));

    idle_link();
    repeat (4) @(negedge clock);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Streams a program image from a byte-wide host link into instruction memory and holds the processor core in reset until the image has been written and its checksum verified. It sits upstream of the mips32 top level. It drives the instruction-memory write port and the core's reset, so a test program can be replaced without re-synthesising the memory initialisation.

## Interface
Parameters:
- MAX_WORDS, 256: largest accepted image, in 32-bit words.
- IDX_W, 9: word-index counter width; must satisfy 2^IDX_W > MAX_WORDS.

Ports:
- clock, in, 1: single system clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low; forces every register to its reset value immediately.
- start, in, 1: begin (or restart) a load; sampled on the rising edge.
- in_data, in, 8: host byte.
- in_valid, in, 1: host byte valid.
- in_ready, out, 1: loader can accept a byte.
- imem_we, out, 1: instruction-memory write strobe, one cycle per word.
- imem_addr, out, 32: byte address of the word being written (word index × 4).
- imem_wdata, out, 32: assembled instruction word.
- core_reset, out, 1: active-high hold for the mips32 core.
- done, out, 1: image loaded and checksum matched.
- error, out, 1: image rejected.

## Operation
- **Image format:** all fields big-endian.
  - LEN_HI byte, then LEN_LO byte: word count N (16-bit).
  - N×4 data bytes; the first byte received is bits [31:24] of the word.
  - One checksum byte equal to the XOR of every preceding image byte, including both length bytes.
- **IDLE:** core_reset = 1, in_ready = 0. start → LEN_HI; the running checksum and word index are cleared.
- **LEN_HI / LEN_LO:** accept one byte each and capture N.
  - After LEN_LO: if N > MAX_WORDS → ERROR; if N = 0 → CHECK; otherwise → DATA with byte counter = 0.
- **DATA:** accept bytes and shift them into the assembly register. On the 4th byte → WRITE.
- **WRITE:** one cycle, in_ready = 0, with imem_we = 1, imem_addr = idx×4, imem_wdata = assembled word.
  - Next cycle idx increments; if idx+1 = N → CHECK, else → DATA.
- **CHECK:** accept one byte.
  - If it equals the running XOR → RUN.
  - Otherwise → ERROR. Instruction memory keeps the partial image, and the core stays in reset.
- **RUN:** core_reset = 0, done = 1, in_ready = 0. Bytes arriving in this state are ignored.
- **ERROR:** error = 1, core_reset = 1, in_ready = 0.
- **start while not IDLE:** from any state other than IDLE, start aborts or restarts. The next state is LEN_HI, with done/error cleared and core_reset reasserted in the same edge.
- **start has priority** over a byte accepted on the same edge; that byte is discarded.
- imem_addr and imem_wdata hold their last values outside WRITE. Only imem_we qualifies a write.

## Timing
- **Reset values:** in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, done 0, error 0, state IDLE.
- **Handshake:** a byte transfers on a rising edge where in_valid & in_ready = 1.
  - in_ready is a registered function of state, with no combinational path from in_valid.
  - The host may hold in_valid high indefinitely; in_data must be stable while in_valid & !in_ready.
- **Throughput:** with in_valid held high, each word costs 5 cycles (4 accept + 1 WRITE).
- **Write latency:** imem_we asserts the cycle after the 4th byte of a word is accepted.
- **Release latency:** core_reset falls and done rises on the edge that accepts a matching checksum byte, so the core leaves reset the following cycle.
- **Reset mid-load:** asserting reset mid-load clears all state at once. The instruction memory is not rolled back.
- **Boundaries:**
  - N = MAX_WORDS is accepted.
  - N = MAX_WORDS+1 goes to ERROR after LEN_LO, without consuming data bytes.
  - The index counter must not wrap for any legal N.

## Test plan
- **Reset:** hold reset low for 3 cycles with start = 1 → all outputs at reset values; after release with start = 0, the block stays in IDLE.
- **Normal load:** start, then stream 00 02 20 08 00 05 00 00 00 00 and checksum 0x2F, in_valid always high → imem_we pulses exactly twice: addr 0x0 data 0x20080005, addr 0x4 data 0x00000000. done = 1 and core_reset = 0 on the cycle after the checksum is accepted.
- **Bad checksum:** same image with checksum 0x2E → error = 1, done = 0, core_reset = 1. Then start → error clears, and a correct reload reaches RUN.
- **Oversize and empty images:**
  - N = 0x0101 with MAX_WORDS = 256 → ERROR right after LEN_LO, with no imem_we.
  - N = 0 followed by checksum 0x00 → RUN with no writes.
- **Backpressure and gaps:** randomly toggle in_valid across a 4-word image → written words and addresses are identical to the ungapped run, and in_ready is low in every WRITE cycle.
- **Abort:** assert start during the 3rd data word → core_reset stays 1. The next byte is treated as LEN_HI, and a full reload completes with done = 1.
